// File: rtl/csu_dac_sequencer.sv
// Power sequencing, code-to-enable mapping and glitch-limited thermometer ramping for the CSU DAC array.
// Define CSU_DEM_EN to rotate thermometer unit selection (dynamic element matching).
module csu_dac_sequencer #(
  parameter int SETTLE_CYCLES = 64,
  parameter int CODE_MAX      = 1151
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        code_valid,
  input  logic [10:0] code,
  output logic        code_ready,
  input  logic        red_sel,
  input  logic [1:0]  atb_sel,
  output logic        pdb,
  output logic [1:0]  atb_ena,
  output logic [16:0] them_en,
  output logic [5:0]  bin_en,
  output logic        bin_red_en,
  output logic        active,
  output logic        code_sat
);

  localparam int          NU         = 17;
  localparam int          SW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [10:0] CODE_MAX_L = 11'(CODE_MAX);

  typedef enum logic [2:0] {S_OFF, S_SETTLE, S_ACTIVE, S_RAMP, S_DOWN} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [4:0]     ptr_q, ptr_d;
  logic [4:0]     tgt_cnt_q, tgt_cnt_d;
  logic [5:0]     tgt_bin_q, tgt_bin_d;
  logic [5:0]     app_q, app_d;
  logic           pend_q, pend_d;
  logic           code_sat_q, code_sat_d;
  logic           pdb_q, pdb_d;
  logic           code_ready_q, code_ready_d;
  logic           active_q, active_d;
  logic [1:0]     atb_ena_q, atb_ena_d;
  logic [16:0]    them_en_q, them_en_d;
  logic [5:0]     bin_en_q, bin_en_d;
  logic           bin_red_en_q, bin_red_en_d;

  logic [10:0]    tgt_full;
  logic           go_down;

`ifdef CSU_DEM_EN
  logic [4:0]     ptr_inc;
  assign ptr_inc = (ptr_q == 5'd16) ? 5'd0 : ptr_q + 5'd1;
`endif

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    tgt_cnt_d  = tgt_cnt_q;
    tgt_bin_d  = tgt_bin_q;
    app_d      = app_q;
    pend_d     = pend_q;
    code_sat_d = code_sat_q;
    go_down    = 1'b0;
    tgt_full   = (code > CODE_MAX_L) ? CODE_MAX_L : code;

    case (state_q)
      S_OFF: begin
        cnt_d  = '0;
        app_d  = '0;
        pend_d = 1'b0;
        if (enable) begin
          state_d  = S_SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (!enable)
          state_d = S_OFF;
        else if (settle_q == '0)
          state_d = S_ACTIVE;
        else
          settle_d = settle_q - SW'(1);
      end
      S_ACTIVE: begin
        if (!enable) begin
          go_down = 1'b1;
        end else begin
          // Equal-count transfers apply their bits one edge after acceptance.
          if (pend_q) begin
            app_d  = tgt_bin_q;
            pend_d = 1'b0;
          end
          if (code_valid) begin
            tgt_cnt_d  = tgt_full[10:6];
            tgt_bin_d  = tgt_full[5:0];
            code_sat_d = (code > CODE_MAX_L);
            if (tgt_full[10:6] == cnt_q) begin
              pend_d = 1'b1;
            end else begin
              pend_d  = 1'b0;
              state_d = S_RAMP;
            end
          end
        end
      end
      S_RAMP: begin
        if (!enable) begin
          go_down = 1'b1;
        end else begin
          if (cnt_q < tgt_cnt_q) begin
            cnt_d = cnt_q + 5'd1;
          end else begin
            cnt_d = cnt_q - 5'd1;
`ifdef CSU_DEM_EN
            ptr_d = ptr_inc;
`endif
          end
          if (cnt_d == tgt_cnt_q) begin
            app_d   = tgt_bin_q;
            state_d = S_ACTIVE;
          end
        end
      end
      S_DOWN: go_down = 1'b1;
      default: state_d = S_OFF;
    endcase

    // Shutdown removes one unit per clock; pdb falls with the last one.
    if (go_down) begin
      state_d = S_DOWN;
      app_d   = '0;
      pend_d  = 1'b0;
      if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
`ifdef CSU_DEM_EN
        ptr_d = ptr_inc;
`endif
      end
      if (cnt_d == 5'd0)
        state_d = S_OFF;
    end

    pdb_d        = (state_d != S_OFF);
    code_ready_d = (state_d == S_ACTIVE);
    active_d     = (state_d == S_ACTIVE) || (state_d == S_RAMP);
    atb_ena_d    = active_d ? atb_sel : 2'b00;
    bin_en_d     = red_sel ? {app_d[5:1], 1'b0} : app_d;
    bin_red_en_d = red_sel & app_d[0];
  end

  // Unit gi is on when its distance past the pointer (mod 17) is below the count.
  for (genvar gi = 0; gi < NU; gi++) begin : g_unit
    localparam logic [4:0] IDX = 5'(gi);
    logic [5:0] wrap;
    logic [4:0] off;
    assign wrap          = {1'b0, IDX} + 6'd17 - {1'b0, ptr_d};
    assign off           = (IDX >= ptr_d) ? (IDX - ptr_d) : wrap[4:0];
    assign them_en_d[gi] = (off < cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OFF;
      settle_q     <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      tgt_cnt_q    <= '0;
      tgt_bin_q    <= '0;
      app_q        <= '0;
      pend_q       <= 1'b0;
      code_sat_q   <= 1'b0;
      pdb_q        <= 1'b0;
      code_ready_q <= 1'b0;
      active_q     <= 1'b0;
      atb_ena_q    <= 2'b00;
      them_en_q    <= '0;
      bin_en_q     <= '0;
      bin_red_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      tgt_cnt_q    <= tgt_cnt_d;
      tgt_bin_q    <= tgt_bin_d;
      app_q        <= app_d;
      pend_q       <= pend_d;
      code_sat_q   <= code_sat_d;
      pdb_q        <= pdb_d;
      code_ready_q <= code_ready_d;
      active_q     <= active_d;
      atb_ena_q    <= atb_ena_d;
      them_en_q    <= them_en_d;
      bin_en_q     <= bin_en_d;
      bin_red_en_q <= bin_red_en_d;
    end
  end

  assign pdb        = pdb_q;
  assign code_ready = code_ready_q;
  assign active     = active_q;
  assign atb_ena    = atb_ena_q;
  assign them_en    = them_en_q;
  assign bin_en     = bin_en_q;
  assign bin_red_en = bin_red_en_q;
  assign code_sat   = code_sat_q;

endmodule

// File: doc/csu_dac_sequencer.md
# csu_dac_sequencer

Digital control block that drives the thermometer/binary current-source array (17 thermometer units of 64 LSB, 6 binary bits, 1 redundant LSB).
- Sequences power-up and power-down of the array through `pdb`.
- Converts a DAC code into unit and bit enables.
- Limits thermometer switching to one unit per clock to bound output glitches.
- Optionally rotates unit selection for dynamic element matching.
- Sits between the digital code source and the analog current-source array.

## Interface
Parameters:
- `SETTLE_CYCLES`, 64: clocks `pdb` is held high before the first code is accepted (min 1).
- `CODE_MAX`, 1151: full-scale code (17·64+63); fixed by array topology.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high; the only reset.
- `enable` in 1: request array powered and active.
- `code_valid` in 1: code handshake valid.
- `code` in 11: requested DAC code, unsigned.
- `code_ready` out 1: sequencer can accept a code.
- `red_sel` in 1: route LSB to the redundant source instead of `bin_en[0]`.
- `atb_sel` in 2: requested analog testbus selection.
- `pdb` out 1: array power-down negate.
- `atb_ena` out 2: testbus selection to the array.
- `them_en` out 17: thermometer unit enables.
- `bin_en` out 6: binary bit enables (bit 5 = MSB).
- `bin_red_en` out 1: redundant LSB enable.
- `active` out 1: high in ACTIVE and RAMP.
- `code_sat` out 1: last accepted code was clipped.

## Operation
States: OFF, SETTLE, ACTIVE, RAMP, DOWN.

Transitions:
- **OFF**: `pdb`=0, all enables 0. On `enable`=1, go to SETTLE and load the settle counter with `SETTLE_CYCLES`-1.
- **SETTLE**: `pdb`=1, enables 0. Decrement the counter each clock; at 0 go to ACTIVE. If `enable`=0, go to OFF immediately.
- **ACTIVE**: `code_ready`=1.
  - A transfer happens when `code_valid` and `code_ready` are both high.
  - On a transfer: target = min(`code`, 1151); `code_sat` = (`code` > 1151).
  - `tgt_cnt` = target[10:6]. This is at most 17 because the target is already clipped.
  - `tgt_bin` = target[5:0].
  - If `tgt_cnt` equals the current count `cnt`, apply the binary bits on the next edge and stay in ACTIVE. Otherwise go to RAMP.
- **RAMP**: `code_ready`=0. Each clock, `cnt` moves by ±1 toward `tgt_cnt`. On the edge where `cnt` reaches `tgt_cnt`, apply the binary bits and go to ACTIVE.
- **DOWN**: entered from ACTIVE or RAMP when `enable`=0 (this has priority over a transfer in the same cycle).
  - Binary bits and `bin_red_en` are cleared on entry.
  - `cnt` decrements by 1 per clock.
  - When `cnt` is 0, go to OFF; `pdb` drops on that same edge.
  - `enable`=1 during DOWN is ignored until OFF is reached.

Binary mapping:
- `red_sel`=0: `bin_en` = applied bits, `bin_red_en`=0.
- `red_sel`=1: `bin_en[5:1]` = bits[5:1], `bin_en[0]`=0, `bin_red_en`=bit0.
- `red_sel` is sampled every clock and is not part of the handshake.

Unit selection without DEM:
- `them_en[i]` = (i < `cnt`).
- An increment enables unit `cnt`; a decrement disables unit `cnt`-1.

Testbus:
- `atb_ena` is registered from `atb_sel` while in ACTIVE or RAMP; otherwise it is 00.

## Timing
- Reset value of every output: `pdb`=0, `atb_ena`=00, `them_en`=0, `bin_en`=0, `bin_red_en`=0, `code_ready`=0, `active`=0, `code_sat`=0. Internally, state=OFF, `cnt`=0, pointer=0.
- `enable` rise at edge E: `pdb`=1 after E+1, `code_ready`=1 after E+1+`SETTLE_CYCLES`.
- Transfer at edge N with thermometer delta D = |`tgt_cnt` − `cnt`|:
  - the final outputs are visible after edge N+max(D,1);
  - `code_ready` is high again in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- At most one `them_en` bit changes per clock, in every state.
- `rst` mid-ramp: all outputs are forced to their reset values on that edge, with no ramp-down.

## Configuration
- `CSU_DEM_EN` defined: rotating pointer `ptr` (0..16).
  - Enabled set = units `ptr`..`ptr`+`cnt`−1, modulo 17.
  - Increment: enable unit (`ptr`+`cnt`) mod 17.
  - Decrement: disable unit `ptr`, then `ptr` = (`ptr`+1) mod 17.
  - Every unit's usage rotates over time.
- `CSU_DEM_EN` undefined: `ptr` is constant 0 and the mapping is exactly as in Operation.

## Test plan
- Reset, then `enable`=1 with `SETTLE_CYCLES`=4 → `pdb`=1 after 1 clock, `code_ready`=1 after 5 clocks, all enables 0.
- From code 0, send code 200 → `them_en` steps 0x1, 0x3, 0x7 on 3 consecutive clocks; `bin_en`=6'b001000 on the 3rd; `code_ready` returns on that clock.
- Send code 2047 → `code_sat`=1; final `them_en`=17'h1FFFF and `bin_en`=6'h3F after 17 steps (starting from 0). A later code of 64 gives `code_sat`=0 and `them_en`=0x1.
- `red_sel`=1 with code 1 → `bin_en`=0, `bin_red_en`=1; toggling `red_sel` to 0 → `bin_en`=1, `bin_red_en`=0 on the next edge.
- `enable`=0 while `cnt`=5 → binary bits cleared, `them_en` decrements over 5 clocks, `pdb`=0 on the 5th; `rst` asserted mid-ramp → all outputs 0 on that edge.
- With `CSU_DEM_EN`: code 128, then 64, then 128 → enabled units {0,1}, then {1}, then {1,2}.
